// File: rtl/dma_page_addr_latch_if.sv
// Bus bundle between the DMA controller/CPU side and the page address latch.
`timescale 1ns/1ps
interface dma_page_addr_latch_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned PAGE_W = 4
);
    localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned ADDR_W = 16 + PAGE_W;

    logic [7:0]        DB;
    logic              ADSTB;
    logic              AEN;
    logic [7:0]        A_LO;
    logic [NCH-1:0]    DACK;
    logic              PG_WR;
    logic [SEL_W-1:0]  PG_SEL;
    logic [PAGE_W-1:0] PG_DIN;
    logic              WRAP_CLR;
    logic [ADDR_W-1:0] SYS_ADDR;
    logic              ADDR_VALID;
    logic [SEL_W-1:0]  CH_ACT;
    logic              WRAP_ERR;
    logic              DACK_ERR;

    modport slave (
        input  DB, ADSTB, AEN, A_LO, DACK, PG_WR, PG_SEL, PG_DIN, WRAP_CLR,
        output SYS_ADDR, ADDR_VALID, CH_ACT, WRAP_ERR, DACK_ERR
    );

    modport master (
        output DB, ADSTB, AEN, A_LO, DACK, PG_WR, PG_SEL, PG_DIN, WRAP_CLR,
        input  SYS_ADDR, ADDR_VALID, CH_ACT, WRAP_ERR, DACK_ERR
    );
endinterface

// File: rtl/dma_page_addr_latch.sv
// Rebuilds the full DMA system address from the strobed high byte, A0-A7 and a
// per-channel page register; flags 64K wrap and DACK protocol errors.
`timescale 1ns/1ps
module dma_page_addr_latch #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned PAGE_W = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    dma_page_addr_latch_if.slave bus
);
    localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned ADDR_W = 16 + PAGE_W;

    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t                  state_q, state_d;
    logic [PAGE_W-1:0]       page_q [NCH];
    logic [PAGE_W-1:0]       page_d [NCH];
    logic [PAGE_W-1:0]       page_snap_q, page_snap_d;
    logic [7:0]              hi_latch_q, hi_latch_d;
    logic [ADDR_W-1:0]       sys_addr_q, sys_addr_d;
    logic                    addr_valid_q, addr_valid_d;
    logic [SEL_W-1:0]        ch_act_q, ch_act_d;
    logic                    wrap_err_q, wrap_err_d;
    logic                    dack_err_q, dack_err_d;

    logic                    dack_onehot;
    logic [SEL_W-1:0]        dack_idx;
    logic [NCH-1:0]          ch_mask;
    logic [7:0]              hi_next;
    logic                    wrap_set;
    logic                    dack_set;

    // DACK decode: one-hot test and index of the set bit
    always_comb begin
        dack_onehot = (bus.DACK != '0) && ((bus.DACK & (bus.DACK - NCH'(1))) == '0);
        dack_idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.DACK[i]) dack_idx = SEL_W'(i);
        end
        ch_mask = NCH'(1) << ch_act_q;
        hi_next = bus.ADSTB ? bus.DB : hi_latch_q;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.AEN) state_d = GRANT;
            GRANT:   if (!bus.AEN) state_d = IDLE;
                     else if (bus.ADSTB) state_d = XFER;
            XFER:    if (!bus.AEN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and flag next values
    always_comb begin
        page_d       = page_q;
        page_snap_d  = page_snap_q;
        hi_latch_d   = bus.ADSTB ? bus.DB : hi_latch_q;
        sys_addr_d   = sys_addr_q;
        addr_valid_d = 1'b0;
        ch_act_d     = ch_act_q;
        wrap_set     = 1'b0;
        dack_set     = 1'b0;

        if (bus.PG_WR) page_d[bus.PG_SEL] = bus.PG_DIN;

        case (state_q)
            IDLE: begin
                if (bus.AEN) begin
                    if (dack_onehot) begin
                        ch_act_d    = dack_idx;
                        page_snap_d = page_q[dack_idx];
                    end else begin
                        dack_set    = 1'b1;
                        page_snap_d = '0;
                    end
                end
            end
            GRANT: begin
                if (bus.AEN) begin
                    dack_set = !dack_onehot || (bus.DACK != ch_mask);
                    if (bus.ADSTB) begin
                        sys_addr_d   = {page_snap_q, hi_next, bus.A_LO};
                        addr_valid_d = 1'b1;
                    end
                end
            end
            XFER: begin
                wrap_set = bus.ADSTB &&
                           (((hi_latch_q == 8'hFF) && (bus.DB == 8'h00)) ||
                            ((hi_latch_q == 8'h00) && (bus.DB == 8'hFF)));
                if (bus.AEN) begin
                    dack_set     = !dack_onehot || (bus.DACK != ch_mask);
                    sys_addr_d   = {page_snap_q, hi_next, bus.A_LO};
                    addr_valid_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Set beats clear on the sticky flags
        wrap_err_d = wrap_set ? 1'b1 : (bus.WRAP_CLR ? 1'b0 : wrap_err_q);
        dack_err_d = dack_set ? 1'b1 : (bus.WRAP_CLR ? 1'b0 : dack_err_q);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NCH; i++) page_q[i] <= '0;
            page_snap_q  <= '0;
            hi_latch_q   <= '0;
            sys_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            ch_act_q     <= '0;
            wrap_err_q   <= 1'b0;
            dack_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) page_q[i] <= page_d[i];
            page_snap_q  <= page_snap_d;
            hi_latch_q   <= hi_latch_d;
            sys_addr_q   <= sys_addr_d;
            addr_valid_q <= addr_valid_d;
            ch_act_q     <= ch_act_d;
            wrap_err_q   <= wrap_err_d;
            dack_err_q   <= dack_err_d;
        end
    end

    assign bus.SYS_ADDR   = sys_addr_q;
    assign bus.ADDR_VALID = addr_valid_q;
    assign bus.CH_ACT     = ch_act_q;
    assign bus.WRAP_ERR   = wrap_err_q;
    assign bus.DACK_ERR   = dack_err_q;
endmodule

// File: tb/tb_dma_page_addr_latch.sv
// Directed bench for dma_page_addr_latch with hand-computed expectations.
`timescale 1ns/1ps
module tb_dma_page_addr_latch;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    dma_page_addr_latch_if #(.NCH(4), .PAGE_W(4)) bus ();

    dma_page_addr_latch #(.NCH(4), .PAGE_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are then read 1 ns after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.DB = 8'h00; bus.ADSTB = 1'b0; bus.AEN = 1'b0; bus.A_LO = 8'h00;
        bus.DACK = 4'b0000; bus.PG_WR = 1'b0; bus.PG_SEL = 2'd0;
        bus.PG_DIN = 4'h0; bus.WRAP_CLR = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b0;
        #12;
        n_vec++; if (bus.SYS_ADDR !== 20'h0) begin n_err++; $display("FAIL rst_addr got %h exp %h", bus.SYS_ADDR, 20'h0); end
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", bus.ADDR_VALID); end
        n_vec++; if (bus.CH_ACT !== 2'd0) begin n_err++; $display("FAIL rst_ch got %0d exp 0", bus.CH_ACT); end
        n_vec++; if (bus.WRAP_ERR !== 1'b0) begin n_err++; $display("FAIL rst_wrap got %b exp 0", bus.WRAP_ERR); end
        n_vec++; if (bus.DACK_ERR !== 1'b0) begin n_err++; $display("FAIL rst_dack got %b exp 0", bus.DACK_ERR); end
        @(negedge CLK);
        RESET = 1'b1;
        step();
    endtask

    task automatic test_first_xfer();
        bus.PG_WR = 1'b1; bus.PG_SEL = 2'd2; bus.PG_DIN = 4'hA;
        step();
        bus.PG_WR = 1'b0; bus.AEN = 1'b1; bus.DACK = 4'b0100;
        step();
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL grant_valid got %b exp 0", bus.ADDR_VALID); end
        bus.DB = 8'h12; bus.ADSTB = 1'b1; bus.A_LO = 8'h34;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'hA1234) begin n_err++; $display("FAIL first_addr got %h exp %h", bus.SYS_ADDR, 20'hA1234); end
        n_vec++; if (bus.ADDR_VALID !== 1'b1) begin n_err++; $display("FAIL first_valid got %b exp 1", bus.ADDR_VALID); end
        n_vec++; if (bus.CH_ACT !== 2'd2) begin n_err++; $display("FAIL first_ch got %0d exp 2", bus.CH_ACT); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  lo  [3];
        logic [7:0]  hi  [3];
        logic        stb [3];
        logic [19:0] exp [3];
        lo[0] = 8'hFE; hi[0] = 8'h00; stb[0] = 1'b0; exp[0] = 20'hA12FE;
        lo[1] = 8'hFF; hi[1] = 8'h00; stb[1] = 1'b0; exp[1] = 20'hA12FF;
        lo[2] = 8'h00; hi[2] = 8'h13; stb[2] = 1'b1; exp[2] = 20'hA1300;
        for (int i = 0; i < 3; i++) begin
            bus.A_LO = lo[i]; bus.DB = hi[i]; bus.ADSTB = stb[i];
            step();
            n_vec++; if (bus.SYS_ADDR !== exp[i]) begin n_err++; $display("FAIL blk_addr%0d got %h exp %h", i, bus.SYS_ADDR, exp[i]); end
        end
        n_vec++; if (bus.WRAP_ERR !== 1'b0) begin n_err++; $display("FAIL blk_wrap got %b exp 0", bus.WRAP_ERR); end
        bus.ADSTB = 1'b0;
    endtask

    task automatic test_wrap();
        bus.DB = 8'hFF; bus.ADSTB = 1'b1; bus.A_LO = 8'h10;
        step();
        n_vec++; if (bus.WRAP_ERR !== 1'b0) begin n_err++; $display("FAIL wrap_pre got %b exp 0", bus.WRAP_ERR); end
        bus.DB = 8'h00; bus.A_LO = 8'h20;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'hA0020) begin n_err++; $display("FAIL wrap_addr got %h exp %h", bus.SYS_ADDR, 20'hA0020); end
        n_vec++; if (bus.WRAP_ERR !== 1'b1) begin n_err++; $display("FAIL wrap_set got %b exp 1", bus.WRAP_ERR); end
        bus.DB = 8'hFF; bus.WRAP_CLR = 1'b1;
        step();
        n_vec++; if (bus.WRAP_ERR !== 1'b1) begin n_err++; $display("FAIL wrap_setwins got %b exp 1", bus.WRAP_ERR); end
        n_vec++; if (bus.SYS_ADDR !== 20'hAFF20) begin n_err++; $display("FAIL wrap_addr2 got %h exp %h", bus.SYS_ADDR, 20'hAFF20); end
        bus.ADSTB = 1'b0;
        step();
        n_vec++; if (bus.WRAP_ERR !== 1'b0) begin n_err++; $display("FAIL wrap_clr got %b exp 0", bus.WRAP_ERR); end
        bus.WRAP_CLR = 1'b0;
    endtask

    task automatic test_page_mid_window();
        bus.PG_WR = 1'b1; bus.PG_SEL = 2'd2; bus.PG_DIN = 4'h5; bus.A_LO = 8'h40;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'hAFF40) begin n_err++; $display("FAIL pgmid_addr0 got %h exp %h", bus.SYS_ADDR, 20'hAFF40); end
        bus.PG_WR = 1'b0; bus.A_LO = 8'h41;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'hAFF41) begin n_err++; $display("FAIL pgmid_addr1 got %h exp %h", bus.SYS_ADDR, 20'hAFF41); end
        bus.AEN = 1'b0; bus.DACK = 4'b0000;
        step();
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL aen_drop_valid got %b exp 0", bus.ADDR_VALID); end
        n_vec++; if (bus.SYS_ADDR !== 20'hAFF41) begin n_err++; $display("FAIL aen_drop_hold got %h exp %h", bus.SYS_ADDR, 20'hAFF41); end
        bus.AEN = 1'b1; bus.DACK = 4'b0100;
        step();
        bus.DB = 8'h56; bus.ADSTB = 1'b1; bus.A_LO = 8'h78;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'h55678) begin n_err++; $display("FAIL newpage_addr got %h exp %h", bus.SYS_ADDR, 20'h55678); end
        n_vec++; if (bus.DACK_ERR !== 1'b0) begin n_err++; $display("FAIL newpage_dack got %b exp 0", bus.DACK_ERR); end
        bus.ADSTB = 1'b0;
    endtask

    task automatic test_dack_err();
        bus.DACK = 4'b0001; bus.A_LO = 8'h79;
        step();
        n_vec++; if (bus.DACK_ERR !== 1'b1) begin n_err++; $display("FAIL dack_switch got %b exp 1", bus.DACK_ERR); end
        n_vec++; if (bus.CH_ACT !== 2'd2) begin n_err++; $display("FAIL dack_switch_ch got %0d exp 2", bus.CH_ACT); end
        n_vec++; if (bus.SYS_ADDR !== 20'h55679) begin n_err++; $display("FAIL dack_switch_addr got %h exp %h", bus.SYS_ADDR, 20'h55679); end
        bus.DACK = 4'b0100; bus.WRAP_CLR = 1'b1;
        step();
        n_vec++; if (bus.DACK_ERR !== 1'b0) begin n_err++; $display("FAIL dack_clr got %b exp 0", bus.DACK_ERR); end
        bus.WRAP_CLR = 1'b0; bus.AEN = 1'b0; bus.DACK = 4'b0000;
        step();
        bus.AEN = 1'b1; bus.DACK = 4'b0110;
        step();
        n_vec++; if (bus.DACK_ERR !== 1'b1) begin n_err++; $display("FAIL dack_multi got %b exp 1", bus.DACK_ERR); end
        n_vec++; if (bus.CH_ACT !== 2'd2) begin n_err++; $display("FAIL dack_multi_ch got %0d exp 2", bus.CH_ACT); end
        bus.DB = 8'h9A; bus.ADSTB = 1'b1; bus.A_LO = 8'hBC;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'h09ABC) begin n_err++; $display("FAIL dack_multi_page got %h exp %h", bus.SYS_ADDR, 20'h09ABC); end
        bus.ADSTB = 1'b0; bus.DACK = 4'b0100;
    endtask

    task automatic test_reset_mid_window();
        step();
        RESET = 1'b0;
        #2;
        n_vec++; if (bus.SYS_ADDR !== 20'h0) begin n_err++; $display("FAIL amid_addr got %h exp %h", bus.SYS_ADDR, 20'h0); end
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL amid_valid got %b exp 0", bus.ADDR_VALID); end
        n_vec++; if (bus.CH_ACT !== 2'd0) begin n_err++; $display("FAIL amid_ch got %0d exp 0", bus.CH_ACT); end
        n_vec++; if (bus.DACK_ERR !== 1'b0) begin n_err++; $display("FAIL amid_dack got %b exp 0", bus.DACK_ERR); end
        @(negedge CLK);
        RESET = 1'b1;
        step();
        n_vec++; if (bus.CH_ACT !== 2'd2) begin n_err++; $display("FAIL rel_ch got %0d exp 2", bus.CH_ACT); end
        step();
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL rel_valid got %b exp 0", bus.ADDR_VALID); end
        bus.DB = 8'h11; bus.ADSTB = 1'b1; bus.A_LO = 8'h22;
        step();
        n_vec++; if (bus.SYS_ADDR !== 20'h01122) begin n_err++; $display("FAIL rel_addr got %h exp %h", bus.SYS_ADDR, 20'h01122); end
        n_vec++; if (bus.ADDR_VALID !== 1'b1) begin n_err++; $display("FAIL rel_valid2 got %b exp 1", bus.ADDR_VALID); end
    endtask

    task automatic test_aen_fall_with_strobe();
        bus.AEN = 1'b0; bus.ADSTB = 1'b1; bus.DB = 8'h77; bus.A_LO = 8'h33;
        step();
        n_vec++; if (bus.ADDR_VALID !== 1'b0) begin n_err++; $display("FAIL fall_valid got %b exp 0", bus.ADDR_VALID); end
        n_vec++; if (bus.SYS_ADDR !== 20'h01122) begin n_err++; $display("FAIL fall_hold got %h exp %h", bus.SYS_ADDR, 20'h01122); end
        bus.ADSTB = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_xfer();
        test_back_to_back();
        test_wrap();
        test_page_mid_window();
        test_dack_err();
        test_reset_mid_window();
        test_aen_fall_with_strobe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dma_page_addr_latch.md
Name: dma_page_addr_latch

Overview:
- Downstream address stage of the DMA controller: rebuilds the full system address for each DMA bus cycle.
- Captures A8–A15, which the controller multiplexes onto DB and qualifies with ADSTB, and concatenates them with A0–A7 and a per-channel page register (A16 and up).
- Drives the system address bus while AEN is high and flags 64K page-wrap and DACK protocol errors.
- Replaces the external 8282 latch plus 74LS612 page-register pair.

Parameters:
NCH, 4, number of DMA channels (one DACK bit and one page register each)
PAGE_W, 4, page register width (A16..A16+PAGE_W-1)
ADDR_W, 16+PAGE_W, derived system address width; not overridable

Ports:
CLK  in  1  DMA clock; all logic rising-edge
RESET  in  1  asynchronous active-low reset
DB  in  8  DMA data bus, carrying A8–A15 when ADSTB=1
ADSTB  in  1  high-address strobe, synchronous to CLK
AEN  in  1  address enable: DMA owns the bus
A_LO  in  8  A0–A7 from the DMA
DACK  in  NCH  channel acknowledge, active-high, one-hot when legal
PG_WR  in  1  CPU page-register write strobe, one cycle
PG_SEL  in  $clog2(NCH)  page register index
PG_DIN  in  PAGE_W  page write data
WRAP_CLR  in  1  clears WRAP_ERR
SYS_ADDR  out  ADDR_W  registered system address
ADDR_VALID  out  1  SYS_ADDR is valid this cycle
CH_ACT  out  $clog2(NCH)  channel locked for the current window
WRAP_ERR  out  1  sticky: high byte wrapped inside one AEN window
DACK_ERR  out  1  sticky: illegal DACK pattern during a window; cleared by WRAP_CLR

Behaviour:
- Reset (RESET=0, async):
  - state IDLE; all page registers and hi_latch = 0.
  - SYS_ADDR=0, ADDR_VALID=0, CH_ACT=0, WRAP_ERR=0, DACK_ERR=0.
  - Reset mid-window aborts immediately; after release, a new window starts only when AEN is seen high in IDLE.
- Page registers:
  - PG_WR=1 writes PG_DIN into page[PG_SEL] at the clock edge, in any state.
  - Each window uses a page snapshot taken on IDLE->GRANT.
  - A write during an active window, including to the active channel, affects only the next window.
  - A write in the same cycle as IDLE->GRANT: the snapshot takes the old value.
- hi_next = ADSTB ? DB : hi_latch. hi_latch <= DB whenever ADSTB=1, in any state.
- FSM:
  - IDLE: ADDR_VALID=0, SYS_ADDR holds its last value. On AEN=1, go to GRANT.
    - If DACK is one-hot, capture its index into CH_ACT and snapshot page[idx].
    - Otherwise set DACK_ERR, keep the previous CH_ACT, and use a page snapshot of 0.
  - GRANT: waits for the first ADSTB because hi_latch is stale. ADDR_VALID=0.
    - On ADSTB=1, go to XFER in the same cycle.
    - On AEN=0, go to IDLE.
  - XFER: every cycle, SYS_ADDR <= {page_snap, hi_next, A_LO} and ADDR_VALID <= 1.
    - On AEN=0, go to IDLE; ADDR_VALID drops on the next edge.
  - GRANT->XFER via ADSTB also performs the first registered update, so the address appears one clock after the strobe cycle.
- Latency: one CLK from ADSTB/A_LO to SYS_ADDR/ADDR_VALID.
- DACK checking (GRANT/XFER):
  - DACK not one-hot, or different from the captured channel, sets DACK_ERR.
  - The transfer continues with CH_ACT unchanged.
- Wrap detection, in XFER only, on ADSTB=1:
  - (hi_latch==8'hFF && DB==8'h00) or (hi_latch==8'h00 && DB==8'hFF) sets WRAP_ERR.
  - The page is never incremented; the controller wraps within 64K.
- Clearing: WRAP_CLR clears both sticky flags. If WRAP_CLR and a set condition occur in the same cycle, set wins.
- AEN falling with ADSTB high in the same cycle: hi_latch still updates; state goes to IDLE; no SYS_ADDR update.

Test Plan:
- Reset, then PG_WR: PG_SEL=2, PG_DIN=4'hA. AEN=1 with DACK=4'b0100; DB=8'h12 with ADSTB=1; A_LO=8'h34. -> The following cycle: SYS_ADDR=20'hA1234, ADDR_VALID=1, CH_ACT=2.
- Block of 3 transfers with A_LO=FE,FF then ADSTB DB=8'h13, A_LO=00 -> SYS_ADDR sequence A12FE, A12FF, A1300, each one cycle after its input; WRAP_ERR=0.
- hi_latch=8'hFF, ADSTB with DB=8'h00 in XFER -> SYS_ADDR[19:16] stays A; WRAP_ERR=1 next cycle. WRAP_CLR with a simultaneous wrap leaves it at 1; WRAP_CLR alone clears it.
- PG_WR page[2]=4'h5 mid-window -> SYS_ADDR keeps page A until AEN=0. The next window on channel 2 yields 5xxxx.
- DACK=4'b0110 at AEN rise, or DACK switching 0100->0001 mid-XFER -> DACK_ERR=1; CH_ACT unchanged.
- RESET pulsed low during XFER -> all outputs 0 asynchronously, page registers 0. With AEN still high after release, GRANT is entered and ADDR_VALID=0 until the next ADSTB.
